// File: rtl/bus_cycle_responder.sv
// Closes 68k bus cycles: latches the decoded region, inserts per-region wait states,
// forwards registered external acknowledges and raises BERR when no acknowledge arrives.
module bus_cycle_responder #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic CanBusSelect_H,
  input  logic DramSelect_H,
  input  logic OffBoardMemory_H,
  input  logic CanBusDtack_L,
  input  logic DramDtack_L,
  input  logic OffBoardDtack_L,
  output logic Dtack_L,
  output logic BErr_L,
  output logic CycleActive_H
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXT,
    S_ACK,
    S_BERR
  } state_t;

  typedef enum logic [2:0] {
    R_NONE,
    R_ROM,
    R_RAM,
    R_IO,
    R_CAN,
    R_DRAM,
    R_OFF
  } region_t;

  state_t      r_state;
  region_t     r_region;
  logic [3:0]  r_wait_cnt;
  logic [7:0]  r_tmo_cnt;
  logic        r_can_ack_l;
  logic        r_dram_ack_l;
  logic        r_off_ack_l;

  region_t     w_region;
  logic        w_start;
  logic        w_internal;
  logic [3:0]  w_wait_load;
  logic        w_ext_ack;
  logic [7:0]  w_tmo_next;
  logic        w_timeout;

  assign w_start = !AS_L && (!UDS_L || !LDS_L);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_region = R_NONE;
    if (OnChipRomSelect_H)      w_region = R_ROM;
    else if (OnChipRamSelect_H) w_region = R_RAM;
    else if (IOSelect_H)        w_region = R_IO;
    else if (CanBusSelect_H)    w_region = R_CAN;
    else if (DramSelect_H)      w_region = R_DRAM;
    else if (OffBoardMemory_H)  w_region = R_OFF;
  end

  always_comb begin
    w_wait_load = 4'd0;
    w_internal  = 1'b0;
    case (w_region)
      R_ROM: begin w_wait_load = 4'(ROM_WAIT); w_internal = 1'b1; end
      R_RAM: begin w_wait_load = 4'(RAM_WAIT); w_internal = 1'b1; end
      R_IO:  begin w_wait_load = 4'(IO_WAIT);  w_internal = 1'b1; end
      default: ;
    endcase
  end

  // Only the acknowledge belonging to the latched region may close the cycle.
  always_comb begin
    w_ext_ack = 1'b0;
    case (r_region)
      R_CAN:  w_ext_ack = !r_can_ack_l;
      R_DRAM: w_ext_ack = !r_dram_ack_l;
      R_OFF:  w_ext_ack = !r_off_ack_l;
      default: w_ext_ack = 1'b0;
    endcase
  end

  assign w_tmo_next = (r_tmo_cnt == 8'hFF) ? r_tmo_cnt : r_tmo_cnt + 8'd1;
  assign w_timeout  = (w_tmo_next == 8'(TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      r_state       <= S_IDLE;
      r_region      <= R_NONE;
      r_wait_cnt    <= 4'd0;
      r_tmo_cnt     <= 8'd0;
      r_can_ack_l   <= 1'b1;
      r_dram_ack_l  <= 1'b1;
      r_off_ack_l   <= 1'b1;
      Dtack_L       <= 1'b1;
      BErr_L        <= 1'b1;
      CycleActive_H <= 1'b0;
    end else begin
      r_can_ack_l  <= CanBusDtack_L;
      r_dram_ack_l <= DramDtack_L;
      r_off_ack_l  <= OffBoardDtack_L;

      case (r_state)
        S_IDLE: begin
          Dtack_L <= 1'b1;
          BErr_L  <= 1'b1;
          if (w_start) begin
            r_region      <= w_region;
            r_wait_cnt    <= w_wait_load;
            r_tmo_cnt     <= 8'd0;
            CycleActive_H <= 1'b1;
            if (!w_internal)             r_state <= S_EXT;
            else if (w_wait_load == 4'd0) r_state <= S_ACK;
            else                          r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (AS_L) begin
            r_state       <= S_IDLE;
            CycleActive_H <= 1'b0;
          end else if (r_wait_cnt == 4'd0) begin
            r_state <= S_ACK;
            Dtack_L <= 1'b0;
          end else if (w_timeout) begin
            r_state <= S_BERR;
            BErr_L  <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            r_tmo_cnt  <= w_tmo_next;
          end
        end

        // Acknowledge is tested ahead of timeout so a same-edge ack still completes the cycle.
        S_EXT: begin
          if (AS_L) begin
            r_state       <= S_IDLE;
            CycleActive_H <= 1'b0;
          end else if (w_ext_ack) begin
            r_state <= S_ACK;
            Dtack_L <= 1'b0;
          end else if (w_timeout) begin
            r_state <= S_BERR;
            BErr_L  <= 1'b0;
          end else begin
            r_tmo_cnt <= w_tmo_next;
          end
        end

        S_ACK: begin
          if (AS_L) begin
            r_state       <= S_IDLE;
            Dtack_L       <= 1'b1;
            CycleActive_H <= 1'b0;
          end else begin
            Dtack_L <= 1'b0;
          end
        end

        S_BERR: begin
          if (AS_L) begin
            r_state       <= S_IDLE;
            BErr_L        <= 1'b1;
            CycleActive_H <= 1'b0;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          Dtack_L       <= 1'b1;
          BErr_L        <= 1'b1;
          CycleActive_H <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_responder.sv
// Directed bench for bus_cycle_responder with default parameters; edge k is the k-th rising
// edge after a cycle's inputs are applied, outputs sampled 1 ns after each edge.
module tb_bus_cycle_responder;

  logic Clk = 1'b0;
  logic Reset_H;
  logic AS_L, UDS_L, LDS_L;
  logic OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H;
  logic CanBusSelect_H, DramSelect_H, OffBoardMemory_H;
  logic CanBusDtack_L, DramDtack_L, OffBoardDtack_L;
  logic Dtack_L, BErr_L, CycleActive_H;

  int n_vec = 0;
  int n_err = 0;

  bus_cycle_responder dut (
    .Clk               (Clk),
    .Reset_H           (Reset_H),
    .AS_L              (AS_L),
    .UDS_L             (UDS_L),
    .LDS_L             (LDS_L),
    .OnChipRomSelect_H (OnChipRomSelect_H),
    .OnChipRamSelect_H (OnChipRamSelect_H),
    .IOSelect_H        (IOSelect_H),
    .CanBusSelect_H    (CanBusSelect_H),
    .DramSelect_H      (DramSelect_H),
    .OffBoardMemory_H  (OffBoardMemory_H),
    .CanBusDtack_L     (CanBusDtack_L),
    .DramDtack_L       (DramDtack_L),
    .OffBoardDtack_L   (OffBoardDtack_L),
    .Dtack_L           (Dtack_L),
    .BErr_L            (BErr_L),
    .CycleActive_H     (CycleActive_H)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    OnChipRomSelect_H = 1'b0; OnChipRamSelect_H = 1'b0; IOSelect_H = 1'b0;
    CanBusSelect_H = 1'b0; DramSelect_H = 1'b0; OffBoardMemory_H = 1'b0;
    CanBusDtack_L = 1'b1; DramDtack_L = 1'b1; OffBoardDtack_L = 1'b1;
  endtask

  initial begin
    logic bad;
    bus_idle();

    // Reset held while a ROM cycle is requested: reset wins.
    Reset_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0; OnChipRomSelect_H = 1'b1;
    tick(); tick();
    chk("reset_dtack", Dtack_L, 1'b1);
    chk("reset_berr", BErr_L, 1'b1);
    chk("reset_active", CycleActive_H, 1'b0);
    bus_idle(); Reset_H = 1'b0;
    tick();

    // ROM, 1 wait: Dtack_L low at edge 2; selects dropped after latching.
    AS_L = 1'b0; LDS_L = 1'b0; OnChipRomSelect_H = 1'b1;
    tick();
    chk("rom_e0_active", CycleActive_H, 1'b1);
    chk("rom_e0_dtack", Dtack_L, 1'b1);
    OnChipRomSelect_H = 1'b0;
    tick();
    chk("rom_e1_dtack", Dtack_L, 1'b1);
    tick();
    chk("rom_e2_dtack", Dtack_L, 1'b0);
    chk("rom_e2_berr", BErr_L, 1'b1);
    tick();
    chk("rom_e3_hold", Dtack_L, 1'b0);
    AS_L = 1'b1; LDS_L = 1'b1;
    tick();
    chk("rom_end_dtack", Dtack_L, 1'b1);
    chk("rom_end_active", CycleActive_H, 1'b0);
    tick();

    // RAM, 0 waits, upper strobe: Dtack_L low at edge 1.
    AS_L = 1'b0; UDS_L = 1'b0; OnChipRamSelect_H = 1'b1;
    tick();
    chk("ram_e0_dtack", Dtack_L, 1'b1);
    chk("ram_e0_active", CycleActive_H, 1'b1);
    tick();
    chk("ram_e1_dtack", Dtack_L, 1'b0);
    bus_idle();
    tick();
    chk("ram_end_dtack", Dtack_L, 1'b1);
    tick();

    // IO, 2 waits: Dtack_L low at edge 3.
    AS_L = 1'b0; LDS_L = 1'b0; IOSelect_H = 1'b1;
    tick(); tick(); tick();
    chk("io_e2_dtack", Dtack_L, 1'b1);
    tick();
    chk("io_e3_dtack", Dtack_L, 1'b0);
    bus_idle();
    tick();
    chk("io_end_dtack", Dtack_L, 1'b1);
    tick();

    // DRAM, ack sampled low at edge 5 -> Dtack_L at edge 6; CAN ack pulse ignored.
    AS_L = 1'b0; LDS_L = 1'b0; DramSelect_H = 1'b1;
    tick();
    CanBusDtack_L = 1'b0;
    tick(); tick(); tick();
    chk("dram_can_ignored", Dtack_L, 1'b1);
    CanBusDtack_L = 1'b1;
    tick();
    chk("dram_e4_dtack", Dtack_L, 1'b1);
    DramDtack_L = 1'b0;
    tick();
    chk("dram_e5_dtack", Dtack_L, 1'b1);
    chk("dram_e5_active", CycleActive_H, 1'b1);
    tick();
    chk("dram_e6_dtack", Dtack_L, 1'b0);
    bus_idle();
    tick();
    chk("dram_end_dtack", Dtack_L, 1'b1);
    tick();

    // No select: BErr_L low at edge 255, Dtack_L never low.
    AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    bad = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (Dtack_L !== 1'b1 || BErr_L !== 1'b1) bad = 1'b1;
    end
    chk("tmo_quiet_to_e254", bad, 1'b0);
    tick();
    chk("tmo_e255_berr", BErr_L, 1'b0);
    chk("tmo_e255_dtack", Dtack_L, 1'b1);
    tick();
    chk("tmo_e256_berr", BErr_L, 1'b0);
    bus_idle();
    tick();
    chk("tmo_end_berr", BErr_L, 1'b1);
    chk("tmo_end_dtack", Dtack_L, 1'b1);
    chk("tmo_end_active", CycleActive_H, 1'b0);
    tick();

    // Aborted IO cycle: AS_L high from edge 1, no Dtack_L, idle by edge 2.
    AS_L = 1'b0; LDS_L = 1'b0; IOSelect_H = 1'b1;
    tick();
    bus_idle();
    tick();
    chk("abort_e1_dtack", Dtack_L, 1'b1);
    tick();
    chk("abort_e2_active", CycleActive_H, 1'b0);
    chk("abort_e2_dtack", Dtack_L, 1'b1);
    tick();
    chk("abort_e3_dtack", Dtack_L, 1'b1);

    // Reset mid-WAIT: outputs inactive the next edge.
    AS_L = 1'b0; LDS_L = 1'b0; IOSelect_H = 1'b1;
    tick(); tick();
    chk("rstwait_pre_active", CycleActive_H, 1'b1);
    Reset_H = 1'b1;
    tick();
    chk("rstwait_dtack", Dtack_L, 1'b1);
    chk("rstwait_berr", BErr_L, 1'b1);
    chk("rstwait_active", CycleActive_H, 1'b0);
    bus_idle(); Reset_H = 1'b0;
    tick();

    // ROM+DRAM selects: ROM timing wins, early DRAM ack ignored.
    AS_L = 1'b0; LDS_L = 1'b0; OnChipRomSelect_H = 1'b1; DramSelect_H = 1'b1; DramDtack_L = 1'b0;
    tick();
    tick();
    chk("multi_e1_dtack", Dtack_L, 1'b1);
    tick();
    chk("multi_e2_dtack", Dtack_L, 1'b0);
    bus_idle();
    tick();
    chk("multi_end_dtack", Dtack_L, 1'b1);
    chk("multi_end_active", CycleActive_H, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
